// File: rtl/ready_valid_chunked_adder_pipeline_pkg.sv
// Shared defaults, chunk sizing helper and the per-stage state layout
// for the chunked ready/valid adder pipeline.
package ready_valid_adder_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_NUM_STAGES = 4;

  function automatic int chunk_width(input int width, input int num_stages);
    return width / num_stages;
  endfunction

  // Default-width view of one stage; stages declare the same layout at their own WIDTH.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] a_rem;
    logic [DEFAULT_WIDTH-1:0] b_rem;
    logic [DEFAULT_WIDTH-1:0] sum_acc;
    logic                     carry;
  } stage_state_t;

endpackage

// File: rtl/ready_valid_chunked_adder_pipeline_if.sv
// Operand/result handshake bundle; master drives operands and consumes results,
// slave is the pipeline.
interface ready_valid_chunked_adder_pipeline_if
  import ready_valid_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output flush, in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  flush, in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/ready_valid_chunked_adder_pipeline_adder_chunk_stage.sv
// One pipeline register stage: resolves chunk STAGE_IDX of the sum, forwards the
// operands, and tracks its own valid bit from the load/drain strobes.
module adder_chunk_stage
  import ready_valid_adder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CHUNK     = chunk_width(DEFAULT_WIDTH, DEFAULT_NUM_STAGES),
  parameter int STAGE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_a_rem,
  input  logic [WIDTH-1:0] i_b_rem,
  input  logic [WIDTH-1:0] i_sum_acc,
  input  logic             i_carry,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_a_rem,
  output logic [WIDTH-1:0] o_b_rem,
  output logic [WIDTH-1:0] o_sum_acc,
  output logic             o_carry
);
  localparam int LSB = STAGE_IDX * CHUNK;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_acc;
    logic             carry;
  } stage_t;

  stage_t           r_state;
  stage_t           w_next;
  logic [CHUNK:0]   w_chunk_sum;

  // Chunk add plus load/hold/drain selection; flush clears valid but leaves data alone.
  always_comb begin
    w_chunk_sum = {1'b0, i_a_rem[LSB +: CHUNK]} + {1'b0, i_b_rem[LSB +: CHUNK]}
                + {{CHUNK{1'b0}}, i_carry};
    w_next = r_state;
    if (i_flush) begin
      w_next.valid = 1'b0;
    end else if (i_load) begin
      w_next.valid                  = 1'b1;
      w_next.a_rem                  = i_a_rem;
      w_next.b_rem                  = i_b_rem;
      w_next.sum_acc                = i_sum_acc;
      w_next.sum_acc[LSB +: CHUNK]  = w_chunk_sum[CHUNK-1:0];
      w_next.carry                  = w_chunk_sum[CHUNK];
    end else if (i_drain) begin
      w_next.valid = 1'b0;
    end else begin
      w_next.valid = r_state.valid;
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_valid   = r_state.valid;
  assign o_a_rem   = r_state.a_rem;
  assign o_b_rem   = r_state.b_rem;
  assign o_sum_acc = r_state.sum_acc;
  assign o_carry   = r_state.carry;

endmodule

// File: rtl/ready_valid_chunked_adder_pipeline.sv
// WIDTH-bit adder spread over NUM_STAGES ready/valid stages, one CHUNK-bit slice
// per stage, with bubble-collapsing backpressure and synchronous flush.
module ready_valid_chunked_adder_pipeline
  import ready_valid_adder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  ready_valid_chunked_adder_pipeline_if.slave   bus
);
  localparam int CHUNK = chunk_width(WIDTH, NUM_STAGES);

  logic [NUM_STAGES-1:0] w_v;
  logic [NUM_STAGES-1:0] w_load;
  logic [NUM_STAGES:0]   w_adv;
  logic [WIDTH-1:0]      w_a_rem   [NUM_STAGES];
  logic [WIDTH-1:0]      w_b_rem   [NUM_STAGES];
  logic [WIDTH-1:0]      w_sum_acc [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_carry;

  // Ready chain runs back from the consumer; a stage can advance if empty or its successor advances.
  always_comb begin
    w_adv             = '0;
    w_load            = '0;
    w_adv[NUM_STAGES] = bus.out_ready;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      w_adv[s] = !w_v[s] || w_adv[s+1];
    end
    w_load[0] = bus.in_valid && w_adv[0];
    for (int s = 1; s < NUM_STAGES; s++) begin
      w_load[s] = w_v[s-1] && w_adv[s];
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic             w_c_in;

    if (s == 0) begin : g_first
      assign w_a_in   = bus.a;
      assign w_b_in   = bus.b;
      assign w_sum_in = '0;
      assign w_c_in   = 1'b0;
    end else begin : g_rest
      assign w_a_in   = w_a_rem[s-1];
      assign w_b_in   = w_b_rem[s-1];
      assign w_sum_in = w_sum_acc[s-1];
      assign w_c_in   = w_carry[s-1];
    end

    adder_chunk_stage #(
      .WIDTH     (WIDTH),
      .CHUNK     (CHUNK),
      .STAGE_IDX (s)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_flush   (bus.flush),
      .i_load    (w_load[s]),
      .i_drain   (w_adv[s+1]),
      .i_a_rem   (w_a_in),
      .i_b_rem   (w_b_in),
      .i_sum_acc (w_sum_in),
      .i_carry   (w_c_in),
      .o_valid   (w_v[s]),
      .o_a_rem   (w_a_rem[s]),
      .o_b_rem   (w_b_rem[s]),
      .o_sum_acc (w_sum_acc[s]),
      .o_carry   (w_carry[s])
    );
  end

  // A flushing cycle drops its input anyway, so it may always report ready.
  assign bus.in_ready  = bus.flush || w_adv[0];
  assign bus.out_valid = w_v[NUM_STAGES-1];
  assign bus.sum       = w_sum_acc[NUM_STAGES-1];
  assign bus.carry_out = w_carry[NUM_STAGES-1];

endmodule
